// File: rtl/state_bank_ring.sv
// Ring of NBANK 25-lane state banks shared by loader, permutation engine and drainer.
// Latency: a loaded block is READY the cycle after lane 24; drain output starts the cycle after DONE.
// Backpressure: stopin (registered) holds upstream when the loader has no bank; stopout freezes dout/pushout/firstout.
module state_bank_ring #(
    parameter int WIDTH = 64,
    parameter int NBANK = 4,
    localparam int BW = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushin,
    input  logic             firstin,
    input  logic [WIDTH-1:0] din,
    output logic             stopin,
    output logic             eng_req,
    output logic [BW-1:0]    eng_bank,
    input  logic             eng_go,
    input  logic             eng_done,
    input  logic [2:0]       ax,
    input  logic [2:0]       ay,
    output logic [WIDTH-1:0] rd,
    input  logic [2:0]       wx,
    input  logic [2:0]       wy,
    input  logic             wr,
    input  logic [WIDTH-1:0] wd,
    output logic             pushout,
    output logic             firstout,
    input  logic             stopout,
    output logic [WIDTH-1:0] dout
);

    typedef enum logic [2:0] {
        B_FREE,
        B_LOADING,
        B_READY,
        B_BUSY,
        B_DONE,
        B_DRAINING
    } bank_st_t;

    bank_st_t         st   [NBANK];
    bank_st_t         st_n [NBANK];
    logic [WIDTH-1:0] mem  [NBANK][25];

    logic [BW-1:0]    load_ptr, load_ptr_n;
    logic [BW-1:0]    eng_ptr, eng_ptr_n;
    logic [BW-1:0]    drain_ptr, drain_ptr_n, drain_nb;
    logic [4:0]       load_cnt, load_cnt_n;
    logic [4:0]       drain_cnt, drain_cnt_n;
    logic             pushout_n, firstout_n, stopin_n;
    logic [WIDTH-1:0] dout_n;
    logic             ld_we, eng_we;
    logic [4:0]       ld_lane;

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NBANK - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [4:0] lane_of(input logic [2:0] x, input logic [2:0] y);
        return 5'(x) + 5'(y) * 5'd5;
    endfunction

    assign eng_bank = eng_ptr;
    assign eng_req  = (st[eng_ptr] == B_READY);
    assign eng_we   = wr && (st[eng_ptr] == B_BUSY) && (wx <= 3'd4) && (wy <= 3'd4);
    assign rd       = ((st[eng_ptr] == B_BUSY) && (ax <= 3'd4) && (ay <= 3'd4))
                      ? mem[eng_ptr][lane_of(ax, ay)] : '0;

    // Next-state for bank states, pointers and drain outputs; the three agents
    // only ever touch banks in disjoint states, so their updates never collide.
    always_comb begin
        for (int i = 0; i < NBANK; i++) st_n[i] = st[i];
        load_ptr_n  = load_ptr;
        load_cnt_n  = load_cnt;
        eng_ptr_n   = eng_ptr;
        drain_ptr_n = drain_ptr;
        drain_cnt_n = drain_cnt;
        drain_nb    = ptr_inc(drain_ptr);
        pushout_n   = pushout;
        firstout_n  = firstout;
        dout_n      = dout;
        ld_we       = 1'b0;
        ld_lane     = load_cnt;

        // Loader: firstin always (re)starts the block at lane 0.
        if (pushin && !stopin) begin
            if (firstin) begin
                ld_we          = 1'b1;
                ld_lane        = 5'd0;
                st_n[load_ptr] = B_LOADING;
                load_cnt_n     = 5'd1;
            end else if (load_cnt != 5'd0) begin
                ld_we = 1'b1;
                if (load_cnt == 5'd24) begin
                    st_n[load_ptr] = B_READY;
                    load_cnt_n     = 5'd0;
                    load_ptr_n     = ptr_inc(load_ptr);
                end else begin
                    load_cnt_n = load_cnt + 5'd1;
                end
            end
        end

        // Engine: done takes priority because a BUSY bank cannot also be READY.
        if (st[eng_ptr] == B_BUSY) begin
            if (eng_done) begin
                st_n[eng_ptr] = B_DONE;
                eng_ptr_n     = ptr_inc(eng_ptr);
            end
        end else if ((st[eng_ptr] == B_READY) && eng_go) begin
            st_n[eng_ptr] = B_BUSY;
        end

        // Drainer: present lane 0 on start, advance only when not stalled.
        if (!pushout) begin
            if (st[drain_ptr] == B_DONE) begin
                st_n[drain_ptr] = B_DRAINING;
                pushout_n       = 1'b1;
                firstout_n      = 1'b1;
                dout_n          = mem[drain_ptr][0];
                drain_cnt_n     = 5'd0;
            end
        end else if (!stopout) begin
            if (drain_cnt == 5'd24) begin
                st_n[drain_ptr] = B_FREE;
                drain_ptr_n     = drain_nb;
                drain_cnt_n     = 5'd0;
                if (st[drain_nb] == B_DONE) begin
                    st_n[drain_nb] = B_DRAINING;
                    dout_n         = mem[drain_nb][0];
                    firstout_n     = 1'b1;
                end else begin
                    pushout_n  = 1'b0;
                    firstout_n = 1'b0;
                end
            end else begin
                drain_cnt_n = drain_cnt + 5'd1;
                dout_n      = mem[drain_ptr][drain_cnt + 5'd1];
                firstout_n  = 1'b0;
            end
        end

        // Looking at next state keeps the loader off a bank that is not yet free.
        stopin_n = !((st_n[load_ptr_n] == B_FREE) || (st_n[load_ptr_n] == B_LOADING));
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBANK; i++) st[i] <= B_FREE;
            load_ptr  <= '0;
            load_cnt  <= '0;
            eng_ptr   <= '0;
            drain_ptr <= '0;
            drain_cnt <= '0;
            pushout   <= 1'b0;
            firstout  <= 1'b0;
            stopin    <= 1'b0;
            dout      <= '0;
        end else begin
            for (int i = 0; i < NBANK; i++) st[i] <= st_n[i];
            load_ptr  <= load_ptr_n;
            load_cnt  <= load_cnt_n;
            eng_ptr   <= eng_ptr_n;
            drain_ptr <= drain_ptr_n;
            drain_cnt <= drain_cnt_n;
            pushout   <= pushout_n;
            firstout  <= firstout_n;
            stopin    <= stopin_n;
            dout      <= dout_n;
        end
    end

    // Bank storage; contents survive reset, the states gate their use.
    always_ff @(posedge clk) begin
        if (ld_we) mem[load_ptr][ld_lane] <= din;
        if (eng_we) mem[eng_ptr][lane_of(wx, wy)] <= wd;
    end

endmodule

// File: tb/tb_state_bank_ring.sv
module tb_state_bank_ring;
    localparam int WIDTH = 64;
    localparam int NBANK = 4;

    logic             clk = 1'b0;
    logic             reset, pushin, firstin, stopin, eng_req, eng_go, eng_done;
    logic [WIDTH-1:0] din, rd, wd, dout;
    logic [1:0]       eng_bank;
    logic [2:0]       ax, ay, wx, wy;
    logic             wr, pushout, firstout, stopout;

    int checks = 0;
    int fails  = 0;
    logic [63:0] got[$];
    bit          gotf[$];
    int          gaps;

    always #5 clk = ~clk;

    state_bank_ring #(.WIDTH(WIDTH), .NBANK(NBANK)) dut (
        .clk(clk), .reset(reset), .pushin(pushin), .firstin(firstin), .din(din),
        .stopin(stopin), .eng_req(eng_req), .eng_bank(eng_bank), .eng_go(eng_go),
        .eng_done(eng_done), .ax(ax), .ay(ay), .rd(rd), .wx(wx), .wy(wy), .wr(wr),
        .wd(wd), .pushout(pushout), .firstout(firstout), .stopout(stopout), .dout(dout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; pushin = 1'b0; firstin = 1'b0; din = '0;
        eng_go = 1'b0; eng_done = 1'b0; ax = '0; ay = '0; wx = '0; wy = '0;
        wr = 1'b0; wd = '0; stopout = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic push_word(input bit f, input logic [63:0] d);
        int n;
        n = 0;
        pushin = 1'b1; firstin = f; din = d;
        while (stopin && n < 2000) begin tick; n++; end
        if (n >= 2000) begin
            checks++; fails++;
            $display("FAIL push_timeout stopin=%0b required 0", stopin);
        end
        tick;
        pushin = 1'b0; firstin = 1'b0;
    endtask

    task automatic push_block(input logic [63:0] base);
        for (int i = 0; i < 25; i++) push_word(i == 0, base + 64'(i));
    endtask

    task automatic eng_run;
        int n;
        n = 0;
        while (!eng_req && n < 2000) begin tick; n++; end
        if (n >= 2000) begin
            checks++; fails++;
            $display("FAIL eng_req_timeout eng_req=%0b required 1", eng_req);
        end
        eng_go = 1'b1; tick; eng_go = 1'b0;
        eng_done = 1'b1; tick; eng_done = 1'b0;
    endtask

    task automatic collect(input int n);
        int  budget;
        bit  started;
        budget = 0; started = 1'b0; gaps = 0;
        got.delete(); gotf.delete();
        while (got.size() < n && budget < 5000) begin
            if (pushout) begin
                got.push_back(dout); gotf.push_back(firstout); started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            tick; budget++;
        end
        if (got.size() < n) begin
            checks++; fails++;
            $display("FAIL collect_timeout words=%0d required %0d", got.size(), n);
        end
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (pushout !== 1'b0) begin fails++; $display("FAIL reset_pushout got=%0b exp=0", pushout); end
        checks++; if (firstout !== 1'b0) begin fails++; $display("FAIL reset_firstout got=%0b exp=0", firstout); end
        checks++; if (stopin !== 1'b0) begin fails++; $display("FAIL reset_stopin got=%0b exp=0", stopin); end
        checks++; if (eng_req !== 1'b0) begin fails++; $display("FAIL reset_eng_req got=%0b exp=0", eng_req); end
        checks++; if (eng_bank !== 2'd0) begin fails++; $display("FAIL reset_eng_bank got=%0d exp=0", eng_bank); end
        checks++; if (dout !== 64'd0) begin fails++; $display("FAIL reset_dout got=%0h exp=0", dout); end
    endtask

    task automatic test_basic;
        push_block(64'd1);
        checks++; if (eng_req !== 1'b1) begin fails++; $display("FAIL basic_eng_req got=%0b exp=1", eng_req); end
        checks++; if (eng_bank !== 2'd0) begin fails++; $display("FAIL basic_eng_bank got=%0d exp=0", eng_bank); end
        eng_run;
        collect(25);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got[i] !== 64'(i + 1) || gotf[i] !== (i == 0)) begin
                fails++; $display("FAIL basic_lane%0d got=%0h/%0b exp=%0h/%0b", i, got[i], gotf[i], i + 1, i == 0);
            end
        end
        checks++; if (gaps !== 0) begin fails++; $display("FAIL basic_gaps got=%0d exp=0", gaps); end
        checks++; if (pushout !== 1'b0) begin fails++; $display("FAIL basic_pushout_after got=%0b exp=0", pushout); end
    endtask

    task automatic test_engine_rw;
        logic [63:0] exp;
        push_block(64'd1);
        checks++; if (eng_bank !== 2'd1) begin fails++; $display("FAIL rw_eng_bank got=%0d exp=1", eng_bank); end
        ax = 3'd2; ay = 3'd3; #1;
        checks++; if (rd !== 64'd0) begin fails++; $display("FAIL rw_rd_not_busy got=%0h exp=0", rd); end
        eng_go = 1'b1; tick; eng_go = 1'b0;
        checks++; if (rd !== 64'd18) begin fails++; $display("FAIL rw_rd_2_3 got=%0h exp=18", rd); end
        ax = 3'd5; #1;
        checks++; if (rd !== 64'd0) begin fails++; $display("FAIL rw_rd_x5 got=%0h exp=0", rd); end
        ax = 3'd2; wr = 1'b1; wx = 3'd2; wy = 3'd3; wd = 64'hAA; #1;
        checks++; if (rd !== 64'd18) begin fails++; $display("FAIL rw_no_writethrough got=%0h exp=18", rd); end
        tick; wr = 1'b0; #1;
        checks++; if (rd !== 64'hAA) begin fails++; $display("FAIL rw_rd_after_write got=%0h exp=aa", rd); end
        wr = 1'b1; wx = 3'd5; wy = 3'd0; wd = 64'h55;
        tick; wr = 1'b0; ax = 3'd0; ay = 3'd1; #1;
        checks++; if (rd !== 64'd6) begin fails++; $display("FAIL rw_wx5_ignored got=%0h exp=6", rd); end
        eng_done = 1'b1; tick; eng_done = 1'b0;
        collect(25);
        for (int i = 0; i < 25; i++) begin
            exp = (i == 17) ? 64'hAA : 64'(i + 1);
            checks++;
            if (got[i] !== exp) begin fails++; $display("FAIL rw_lane%0d got=%0h exp=%0h", i, got[i], exp); end
        end
    endtask

    task automatic test_ring_full;
        logic [63:0] exp;
        for (int b = 0; b < 4; b++) push_block(64'(b + 1) << 8);
        checks++; if (stopin !== 1'b1) begin fails++; $display("FAIL full_stopin got=%0b exp=1", stopin); end
        pushin = 1'b1; firstin = 1'b1; din = 64'hDEAD;
        repeat (5) tick;
        pushin = 1'b0; firstin = 1'b0;
        checks++; if (stopin !== 1'b1) begin fails++; $display("FAIL full_stopin_held got=%0b exp=1", stopin); end
        checks++; if (eng_bank !== 2'd2) begin fails++; $display("FAIL full_eng_bank got=%0d exp=2", eng_bank); end
        fork
            begin eng_run; eng_run; end
            collect(50);
        join
        for (int i = 0; i < 50; i++) begin
            exp = (64'(i / 25 + 1) << 8) + 64'(i % 25);
            checks++;
            if (got[i] !== exp || gotf[i] !== (i % 25 == 0)) begin
                fails++; $display("FAIL full_a_word%0d got=%0h/%0b exp=%0h/%0b", i, got[i], gotf[i], exp, i % 25 == 0);
            end
        end
        checks++; if (gaps !== 0) begin fails++; $display("FAIL full_back_to_back_gaps got=%0d exp=0", gaps); end
        checks++; if (stopin !== 1'b0) begin fails++; $display("FAIL full_stopin_released got=%0b exp=0", stopin); end
        push_block(64'd5 << 8);
        fork
            begin eng_run; eng_run; eng_run; end
            collect(75);
        join
        for (int i = 0; i < 75; i++) begin
            exp = (64'(i / 25 + 3) << 8) + 64'(i % 25);
            checks++;
            if (got[i] !== exp) begin fails++; $display("FAIL full_b_word%0d got=%0h exp=%0h", i, got[i], exp); end
        end
    endtask

    task automatic test_partial;
        do_reset;
        push_word(1'b0, 64'h777);
        for (int i = 0; i < 10; i++) push_word(i == 0, 64'h900 + 64'(i));
        push_block(64'hA00);
        checks++; if (eng_bank !== 2'd0) begin fails++; $display("FAIL partial_eng_bank got=%0d exp=0", eng_bank); end
        checks++; if (eng_req !== 1'b1) begin fails++; $display("FAIL partial_eng_req got=%0b exp=1", eng_req); end
        eng_run;
        collect(25);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got[i] !== 64'hA00 + 64'(i) || gotf[i] !== (i == 0)) begin
                fails++; $display("FAIL partial_lane%0d got=%0h/%0b exp=%0h/%0b", i, got[i], gotf[i], 64'hA00 + 64'(i), i == 0);
            end
        end
        checks++; if (pushout !== 1'b0) begin fails++; $display("FAIL partial_pushout_after got=%0b exp=0", pushout); end
        for (int i = 0; i < 25; i++) push_word(1'b0, 64'hB00 + 64'(i));
        checks++; if (eng_req !== 1'b0) begin fails++; $display("FAIL partial_orphans_dropped eng_req=%0b exp=0", eng_req); end
    endtask

    task automatic test_stopout_toggle;
        int          cyc;
        bit          prev_stall;
        logic [63:0] prev_d;
        bit          prev_f;
        cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_f = 1'b0;
        push_block(64'hC00);
        eng_run;
        got.delete(); gotf.delete();
        while (got.size() < 25 && cyc < 500) begin
            stopout = cyc[0];
            if (pushout && prev_stall) begin
                checks++;
                if (dout !== prev_d || firstout !== prev_f) begin
                    fails++; $display("FAIL toggle_hold got=%0h/%0b exp=%0h/%0b", dout, firstout, prev_d, prev_f);
                end
            end
            if (pushout && !stopout) begin got.push_back(dout); gotf.push_back(firstout); end
            prev_stall = pushout && stopout; prev_d = dout; prev_f = firstout;
            tick; cyc++;
        end
        stopout = 1'b0;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got[i] !== 64'hC00 + 64'(i) || gotf[i] !== (i == 0)) begin
                fails++; $display("FAIL toggle_lane%0d got=%0h/%0b exp=%0h/%0b", i, got[i], gotf[i], 64'hC00 + 64'(i), i == 0);
            end
        end
        checks++; if (pushout !== 1'b0) begin fails++; $display("FAIL toggle_pushout_after got=%0b exp=0", pushout); end
    endtask

    task automatic test_reset_mid;
        int n;
        n = 0;
        stopout = 1'b1;
        push_block(64'hD00);
        eng_run;
        while (!pushout && n < 100) begin tick; n++; end
        checks++; if (dout !== 64'hD00 || firstout !== 1'b1) begin fails++; $display("FAIL mid_drain_start got=%0h/%0b exp=d00/1", dout, firstout); end
        push_block(64'hE00);
        checks++; if (eng_req !== 1'b1) begin fails++; $display("FAIL mid_eng_req got=%0b exp=1", eng_req); end
        for (int i = 0; i < 10; i++) push_word(i == 0, 64'hF00 + 64'(i));
        reset = 1'b1;
        tick;
        checks++; if (pushout !== 1'b0) begin fails++; $display("FAIL mid_reset_pushout got=%0b exp=0", pushout); end
        checks++; if (stopin !== 1'b0) begin fails++; $display("FAIL mid_reset_stopin got=%0b exp=0", stopin); end
        checks++; if (eng_req !== 1'b0) begin fails++; $display("FAIL mid_reset_eng_req got=%0b exp=0", eng_req); end
        checks++; if (dout !== 64'd0) begin fails++; $display("FAIL mid_reset_dout got=%0h exp=0", dout); end
        reset = 1'b0; stopout = 1'b0;
        repeat (5) tick;
        checks++; if (pushout !== 1'b0) begin fails++; $display("FAIL mid_no_partial_output got=%0b exp=0", pushout); end
        push_block(64'h1100);
        checks++; if (eng_bank !== 2'd0) begin fails++; $display("FAIL mid_fresh_bank got=%0d exp=0", eng_bank); end
        eng_run;
        collect(25);
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (got[i] !== 64'h1100 + 64'(i) || gotf[i] !== (i == 0)) begin
                fails++; $display("FAIL mid_fresh_lane%0d got=%0h/%0b exp=%0h/%0b", i, got[i], gotf[i], 64'h1100 + 64'(i), i == 0);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_engine_rw;
        test_ring_full;
        test_partial;
        test_stopout_toggle;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
